// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the load/store data memory.
//   size_e  : access size encoding as it appears on i_size
//   state_e : controller states (array clear after reset, then ready)
//   byte_en : byte-lane write mask for a store of a given size at a lane
//   load_ext: extracts and extends a byte/half/word from a memory word
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
    case (size)
      SIZE_B:  byte_en = 4'b0001 << lane;
      SIZE_H:  byte_en = 4'b0011 << lane;
      SIZE_W:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input size_e size,
                                           input logic [1:0] lane, input logic is_unsigned);
    logic [31:0] w_sh;
    w_sh = word >> {lane, 3'b000};
    case (size)
      SIZE_B:  load_ext = is_unsigned ? {24'h0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
      SIZE_H:  load_ext = is_unsigned ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      SIZE_W:  load_ext = word;
      default: load_ext = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: DEPTH_WORDS x 32-bit storage with per-byte write enables and a
// registered read port. The array itself is never reset.
//   i_clk   : clock, rising edge
//   i_we    : byte-lane write enables (bit n writes bits [8n+7:8n])
//   i_re    : read enable; o_rdata updates only on an enabled read
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data (old contents on a same-edge write)
module dmem_bram #(
  parameter int DEPTH_WORDS = 2048,
  parameter int IDXW        = $clog2(DEPTH_WORDS)
) (
  input  logic            i_clk,
  input  logic [3:0]      i_we,
  input  logic            i_re,
  input  logic [IDXW-1:0] i_addr,
  input  logic [31:0]     i_wdata,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q_p1;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_q_p1 <= r_mem[i_addr];
  end

  assign o_rdata = r_q_p1;

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory with load/store-unit semantics for the MEM stage.
// After reset the array is zeroed one word per cycle; requests are then
// accepted one per cycle with a response exactly one cycle later.
//   i_clk      : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   i_req      : request valid;  o_ready: request accepted when both high
//   i_addr     : byte address;   i_we: 1 store / 0 load
//   i_size     : 00 byte, 01 half, 10 word, 11 illegal
//   i_unsigned : zero-extend byte/half loads
//   i_wdata    : right-aligned store data
//   o_rvalid   : one-cycle response pulse
//   o_rdata    : extended load data, 0 for stores and errors
//   o_err      : misaligned, out-of-range or illegal-size request
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int AW          = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_req,
  output logic          o_ready,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [31:0]   i_wdata,
  output logic          o_rvalid,
  output logic [31:0]   o_rdata,
  output logic          o_err
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH_WORDS - 1);

  function automatic logic [31:0] store_repl(input size_e size, input logic [31:0] data);
    case (size)
      SIZE_B:  store_repl = {4{data[7:0]}};
      SIZE_H:  store_repl = {2{data[15:0]}};
      default: store_repl = data;
    endcase
  endfunction

  state_e          r_state;
  logic [IDXW-1:0] r_clr_cnt;
  logic            r_ready;

  logic            r_vld_p1;
  logic            r_err_p1;
  logic            r_ld_ok_p1;
  logic [1:0]      r_lane_p1;
  size_e           r_size_p1;
  logic            r_uns_p1;

  logic [1:0]      w_lane;
  logic [IDXW-1:0] w_idx;
  size_e           w_size;
  logic            w_oor;
  logic            w_err;
  logic            w_accept;
  logic [3:0]      w_bram_we;
  logic            w_bram_re;
  logic [IDXW-1:0] w_bram_addr;
  logic [31:0]     w_bram_wdata;
  logic [31:0]     w_bram_q;

  // Request decode / error check (stage p0)
  assign w_lane   = i_addr[1:0];
  assign w_idx    = i_addr[2 +: IDXW];
  assign w_size   = size_e'(i_size);
  // Any set bit above the index field means the word index is >= DEPTH_WORDS.
  assign w_oor    = |i_addr[AW-1:2+IDXW];
  assign w_err    = (w_size == SIZE_X) ||
                    ((w_size == SIZE_H) && w_lane[0]) ||
                    ((w_size == SIZE_W) && (w_lane != 2'b00)) ||
                    w_oor;
  assign w_accept = i_req && r_ready;

  // The clear walk and normal stores share the single bram write port.
  always_comb begin
    w_bram_we    = 4'b0000;
    w_bram_re    = 1'b0;
    w_bram_addr  = w_idx;
    w_bram_wdata = store_repl(w_size, i_wdata);
    if (r_state == ST_CLEAR) begin
      w_bram_we    = 4'b1111;
      w_bram_addr  = r_clr_cnt;
      w_bram_wdata = 32'h0;
    end else if (w_accept && !w_err) begin
      if (i_we) w_bram_we = byte_en(w_size, w_lane);
      else      w_bram_re = 1'b1;
    end
  end

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDXW        (IDXW)
  ) u_bram (
    .i_clk   (i_clk),
    .i_we    (w_bram_we),
    .i_re    (w_bram_re),
    .i_addr  (w_bram_addr),
    .i_wdata (w_bram_wdata),
    .o_rdata (w_bram_q)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + IDXW'(1);
          if (r_clr_cnt == LAST_IDX) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: r_ready <= 1'b1;
        default: begin
          r_state <= ST_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Response stage p1: aligned with the bram read data. Qualifiers only load
  // on acceptance so the outputs hold between responses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vld_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
      r_ld_ok_p1 <= 1'b0;
      r_lane_p1  <= 2'b00;
      r_size_p1  <= SIZE_W;
      r_uns_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_err_p1   <= w_err;
        r_ld_ok_p1 <= !i_we && !w_err;
        r_lane_p1  <= w_lane;
        r_size_p1  <= w_size;
        r_uns_p1   <= i_unsigned;
      end
    end
  end

  // Output data depends only on p1 registers and the registered bram word;
  // the bram word only changes on an accepted load, so it holds with the rest.
  assign o_ready  = r_ready;
  assign o_rvalid = r_vld_p1;
  assign o_err    = r_err_p1;
  assign o_rdata  = r_ld_ok_p1 ? load_ext(w_bram_q, r_size_p1, r_lane_p1, r_uns_p1) : 32'h0;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

- Parametrised data memory with load/store-unit semantics, the successor to the word-only data memory.
- Adds configurable depth, byte/halfword/word access with byte-lane writes and sign/zero-extended loads, and a registered synchronous read behind a request/response handshake.
- Replaces the single-cycle reset of the array with a hardware clear sequence that walks the array after reset.
- Sits between the core's MEM stage and the data bus/IO decoder.

## Interface
Parameters:
- DEPTH_WORDS, 2048, number of 32-bit words (power of two, ≥ 4)
- AW, 32, byte-address width

Ports:
- i_clk  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  request valid
- o_ready  out  1  block can accept a request this cycle
- i_addr  in  AW  byte address
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for word and stores
- i_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- o_rvalid  out  1  response valid, one-cycle pulse
- o_rdata  out  32  extended load data; 0 for stores and errors
- o_err  out  1  qualified by o_rvalid: misaligned, out-of-range or illegal size

## Operation
- States: CLEAR, READY.
- **Reset (i_reset_n low, asynchronous):**
  - state = CLEAR, clear counter = 0.
  - o_ready = 0, o_rvalid = 0, o_rdata = 0, o_err = 0.
- **CLEAR:**
  - One word is written to 0 per cycle at the clear counter index; the counter increments.
  - After word DEPTH_WORDS-1 is written, go to READY.
  - o_ready = 0; i_req is ignored.
  - Reset asserted mid-clear restarts the clear from index 0.
- **READY:** o_ready = 1. A request is accepted when i_req && o_ready.
- **Word index:** i_addr[AW-1:2]; lane = i_addr[1:0].
- **Error conditions** (any one sets err):
  - i_size == 11.
  - Half with lane[0] != 0.
  - Word with lane != 0.
  - Word index ≥ DEPTH_WORDS.
- **Store, no error:**
  - Byte enables: byte → 1 << lane; half → 2'b11 << lane; word → 4'b1111.
  - Data is replicated to the lanes (byte ×4, half ×2).
  - Written at the accepting edge.
- **Store with error:** no array write.
- **Load, no error:**
  - The word is read synchronously.
  - The selected byte/half is shifted down by lane×8.
  - It is sign-extended unless i_unsigned.
- **Load with error:** no extension logic applied; o_rdata = 0.
- **Response:** the cycle after acceptance, o_rvalid = 1 with o_err and o_rdata. Stores respond with o_rdata = 0.
- **Back-to-back:** one request per cycle sustained. A load accepted the cycle after a store to the same word returns the new data; no forwarding is needed because the write completes at the earlier edge.

## Timing
- Accept at edge N → o_rvalid high during cycle N+1 only, unless another request is accepted at edge N+1.
- Throughput: 1 request/cycle in READY.
- After i_reset_n deasserts, o_ready rises exactly DEPTH_WORDS cycles later.
- o_ready, o_rvalid, o_rdata and o_err are all registered; no combinational input→output paths.
- o_rdata and o_err hold their last values when o_rvalid = 0, except after reset, when they are 0.

## Structure
- Package dmem_pkg contains:
  - enum size_e (SIZE_B, SIZE_H, SIZE_W, SIZE_X).
  - enum state_e (ST_CLEAR, ST_READY).
  - function byte_en(size, lane) returning 4 bits.
  - function load_ext(word, size, lane, unsigned) returning 32 bits.
- One sub-module, dmem_bram, holds the storage:
  - Array of DEPTH_WORDS × 32 bits.
  - 4-bit byte write enable.
  - Registered read, no reset on the array.
- dmem_lsu contains:
  - The FSM and clear counter.
  - Request decode and error check.
  - Store lane replication.
  - A response pipeline register holding lane, size, unsigned and err, which aligns with the bram read data.
- Clear writes go through the same bram write port (we = 4'b1111, data 0) via a mux.

## Test plan
- **Reset clear:** pulse i_reset_n low, release; count cycles → o_ready = 1 after exactly DEPTH_WORDS cycles. A load of word DEPTH_WORDS-1 then returns 0 with o_err = 0.
- **Lane writes:**
  - SW 0x11223344 @0x10, then SB 0xAA @0x11, then LW @0x10 → 0x1122AA44.
  - SH 0xBEEF @0x12, then LW @0x10 → 0xBEEFAA44.
- **Extension** (word 0x80FF7F01 @0x20):
  - LB @0x21 → 0x0000007F.
  - LB @0x22 → 0xFFFFFFFF.
  - LBU @0x22 → 0x000000FF.
  - LH @0x22 → 0xFFFF80FF.
  - LHU @0x22 → 0x000080FF.
- **Errors:**
  - LW @0x22 → o_rvalid = 1, o_err = 1, o_rdata = 0.
  - SH 0x1234 @0x21 → o_err = 1, memory unchanged.
  - size 11 → o_err = 1.
  - Word index DEPTH_WORDS → o_err = 1.
- **Back-to-back:** SW 0xCAFEF00D @0x40 at edge N, LW @0x40 at edge N+1. Responses land on N+1 (store, rdata 0) and N+2 (rdata 0xCAFEF00D), with o_rvalid high both cycles.
- **Reset mid-operation:**
  - Assert i_reset_n low during a pending load response → o_rvalid drops to 0 immediately.
  - Assert i_reset_n low halfway through a clear → after release, a full DEPTH_WORDS-cycle clear runs again, and data stored earlier reads 0.
